// File: rtl/accel_sample_reader.sv
// SPI mode-3 master: writes the accelerometer POWER_CTL register once after reset,
// then reads one 10-bit axis every SAMPLE_PERIOD clocks and presents it as offset binary.
module accel_sample_reader #(
    parameter int          CLK_DIV       = 4,
    parameter int          SAMPLE_PERIOD = 5000,
    parameter logic [7:0]  AXIS_ADDR     = 8'h32
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       spi_cs_n,
    output logic       spi_sclk,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic [7:0] acc_data,
    output logic       acc_valid,
    output logic       busy
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PER_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_PERIOD - 1);

    // A frame of N bits spans half-periods 0..2N+1: setup, N x (low, high), hold.
    localparam logic [5:0] WR_HOLD    = 6'd33;
    localparam logic [5:0] RD_HOLD    = 6'd49;
    localparam logic [5:0] WR_LAST_HI = 6'd32;
    localparam logic [5:0] RD_LAST_HI = 6'd48;

    // Frames are left-aligned so the shifter always drives bit 23.
    localparam logic [23:0] WR_FRAME = {8'h2D, 8'h08, 8'h00};
    localparam logic [23:0] RD_FRAME = {2'b11, AXIS_ADDR[5:0], 16'h0000};

    typedef enum logic [2:0] {
        S_INIT,
        S_XFER,
        S_GAP,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [DIV_W-1:0] div_cnt;
    logic [5:0]       half_cnt;
    logic [PER_W-1:0] period_cnt;
    logic [23:0]      tx_sh;
    logic [15:0]      rx_sh;
    logic             is_read;
    logic [7:0]       data_q;
    logic             valid_q;

    logic       div_last;
    logic       period_last;
    logic [5:0] hold_half;
    logic [5:0] last_high;
    logic       in_xfer;
    logic       xfer_end;
    logic       sclk_low;
    logic       shift_tx;
    logic       sample_rx;

    assign in_xfer     = (state == S_XFER);
    assign div_last    = (div_cnt == DIV_LAST);
    assign period_last = (period_cnt == PER_LAST);
    assign hold_half   = is_read ? RD_HOLD : WR_HOLD;
    assign last_high   = is_read ? RD_LAST_HI : WR_LAST_HI;
    assign xfer_end    = in_xfer && div_last && (half_cnt == hold_half);
    assign sclk_low    = in_xfer && half_cnt[0] && (half_cnt != hold_half);
    // MOSI advances only as SCLK falls into the next bit, never into the hold phase.
    assign shift_tx    = in_xfer && div_last && !half_cnt[0] && (half_cnt != 6'd0)
                         && (half_cnt != last_high);
    assign sample_rx   = in_xfer && (div_cnt == '0) && !half_cnt[0] && (half_cnt != 6'd0);

    assign spi_cs_n  = !in_xfer;
    assign spi_sclk  = !sclk_low;
    assign spi_mosi  = in_xfer && tx_sh[23];
    assign busy      = in_xfer;
    assign acc_data  = data_q;
    assign acc_valid = valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT: state_nxt = S_XFER;
            S_XFER: if (xfer_end) state_nxt = is_read ? S_DONE : S_GAP;
            S_GAP:  if (div_last) state_nxt = S_WAIT;
            S_WAIT: if (period_last) state_nxt = S_XFER;
            S_DONE: state_nxt = S_WAIT;
            default: state_nxt = S_INIT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            half_cnt   <= '0;
            period_cnt <= '0;
            tx_sh      <= '0;
            rx_sh      <= '0;
            is_read    <= 1'b0;
        end else begin
            if ((in_xfer || state == S_GAP) && !div_last) begin
                div_cnt <= div_cnt + 1'b1;
            end else begin
                div_cnt <= '0;
            end

            if (!in_xfer || xfer_end) begin
                half_cnt <= '0;
            end else if (div_last) begin
                half_cnt <= half_cnt + 6'd1;
            end

            // Runs through transfers so read starts stay exactly one period apart.
            if (state == S_GAP || period_last) begin
                period_cnt <= '0;
            end else begin
                period_cnt <= period_cnt + 1'b1;
            end

            if (state == S_INIT) begin
                tx_sh   <= WR_FRAME;
                is_read <= 1'b0;
            end else if (state == S_WAIT && period_last) begin
                tx_sh   <= RD_FRAME;
                is_read <= 1'b1;
            end else if (shift_tx) begin
                tx_sh <= {tx_sh[22:0], 1'b0};
            end

            if (sample_rx) begin
                rx_sh <= {rx_sh[14:0], spi_miso};
            end
        end
    end

    // rx_sh holds {X0, X1}; the 10-bit sample is {X1[1:0], X0}, sign bit inverted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= 8'h80;
            valid_q <= 1'b0;
        end else begin
            valid_q <= (state == S_DONE);
            if (state == S_DONE) begin
                data_q <= {~rx_sh[1], rx_sh[0], rx_sh[15:10]};
            end
        end
    end

endmodule

// File: tb/tb_accel_sample_reader.sv
// Bench for accel_sample_reader: SPI slave model, frame/valid monitors and an
// arithmetic reference for the 10-bit signed to 8-bit offset-binary conversion.
module tb_accel_sample_reader;

    localparam int CLK_DIV       = 2;
    localparam int SAMPLE_PERIOD = 200;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       spi_miso = 1'b0;
    logic       spi_cs_n;
    logic       spi_sclk;
    logic       spi_mosi;
    logic [7:0] acc_data;
    logic       acc_valid;
    logic       busy;

    always #5 clk = ~clk;

    accel_sample_reader #(
        .CLK_DIV      (CLK_DIV),
        .SAMPLE_PERIOD(SAMPLE_PERIOD),
        .AXIS_ADDR    (8'h32)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .spi_cs_n (spi_cs_n),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .acc_data (acc_data),
        .acc_valid(acc_valid),
        .busy     (busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          nbits;
        logic [23:0] data;
        int          start;
        int          len;
    } frame_t;

    frame_t frames[$];
    int     valid_q[$];

    // Collects MOSI on SCLK rising edges for each CS-low window; reset aborts the frame.
    always begin
        frame_t f;
        bit     aborted;
        @(negedge spi_cs_n);
        f.start = cyc;
        f.nbits = 0;
        f.data  = '0;
        aborted = 1'b0;
        forever begin
            @(posedge spi_sclk or posedge spi_cs_n or negedge rst_n);
            if (!rst_n) begin
                aborted = 1'b1;
                break;
            end
            if (spi_cs_n) break;
            f.data  = {f.data[22:0], spi_mosi};
            f.nbits = f.nbits + 1;
        end
        f.len = cyc - f.start;
        if (!aborted) frames.push_back(f);
    end

    always @(posedge acc_valid) valid_q.push_back(cyc);

    // Mode-3 slave: one dummy byte during the command, then X0 and X1, driven on SCLK fall.
    logic [7:0]  resp_x0 = 8'h00;
    logic [7:0]  resp_x1 = 8'h00;
    logic [23:0] sl_sh   = '0;
    always @(negedge spi_cs_n) sl_sh = {8'h00, resp_x0, resp_x1};
    always @(negedge spi_sclk) begin
        if (spi_cs_n === 1'b0) begin
            spi_miso = sl_sh[23];
            sl_sh    = {sl_sh[22:0], 1'b0};
        end
    end

    int         glitches  = 0;
    logic [7:0] prev_data = 8'h80;
    always @(negedge clk) begin
        if (rst_n && acc_data !== prev_data && !acc_valid) glitches++;
        prev_data = acc_data;
    end

    int n_cmp = 0;
    int n_err = 0;
    int prev_vc = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [7:0] x0, input logic [7:0] x1);
        int s;
        s = (int'(x1) * 256 + int'(x0)) % 1024;
        if (s >= 512) s = s - 1024;
        return 8'((s + 512) / 4);
    endfunction

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (valid_q.size() != 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_frame(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (frames.size() != 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cs_n"}, spi_cs_n, 1);
        check({tag, "_sclk"}, spi_sclk, 1);
        check({tag, "_mosi"}, spi_mosi, 0);
        check({tag, "_acc_data"}, acc_data, 8'h80);
        check({tag, "_acc_valid"}, acc_valid, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic check_config(input string tag, input int rel);
        bit     ok;
        frame_t f;
        wait_frame(300, ok);
        check({tag, "_seen"}, ok, 1);
        if (ok) begin
            f = frames.pop_front();
            check({tag, "_nbits"}, f.nbits, 16);
            check({tag, "_data"}, f.data, 24'h002D08);
            check({tag, "_cs_low_len"}, f.len, 34 * CLK_DIV);
            check({tag, "_after_release"}, (f.start >= rel + 1), 1);
            check({tag, "_no_valid"}, valid_q.size(), 0);
        end
    endtask

    task automatic do_read(input logic [7:0] x0, input logic [7:0] x1, input string tag);
        bit     ok;
        int     vc;
        frame_t f;
        resp_x0 = x0;
        resp_x1 = x1;
        wait_valid(600, ok);
        check({tag, "_valid_seen"}, ok, 1);
        if (ok) begin
            vc = valid_q.pop_front();
            check({tag, "_acc_data"}, acc_data, model(x0, x1));
            check({tag, "_frames"}, frames.size(), 1);
            if (frames.size() != 0) begin
                f = frames.pop_front();
                check({tag, "_nbits"}, f.nbits, 24);
                check({tag, "_mosi"}, f.data, 24'hF20000);
                check({tag, "_cs_low_len"}, f.len, 50 * CLK_DIV);
                check({tag, "_valid_latency"}, vc - (f.start + f.len), 1);
            end
            if (prev_vc >= 0) check({tag, "_period"}, vc - prev_vc, SAMPLE_PERIOD);
            prev_vc = vc;
            @(negedge clk);
            check({tag, "_pulse_width"}, acc_valid, 0);
        end
    endtask

    initial begin
        int  rel;
        bit  seen;

        repeat (3) @(negedge clk);
        check_reset_values("por");
        rst_n = 1'b1;
        rel   = cyc;
        check_config("cfg", rel);

        do_read(8'hFC, 8'h01, "pos_fs");
        do_read(8'h00, 8'hFE, "neg_fs");
        do_read(8'h00, 8'h00, "zero");
        do_read(8'hFC, 8'hFF, "minus4");
        for (int i = 0; i < 4; i++) begin
            do_read(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), $sformatf("rnd%0d", i));
        end
        do_read(8'h40, 8'h01, "pre_reset");

        // Abort the next read during bit 10.
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (spi_cs_n === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        check("midread_cs_seen", seen, 1);
        repeat (21 * CLK_DIV) @(negedge clk);
        check("midread_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_reset_values("midread_rst");
        repeat (3) @(negedge clk);
        check("midread_no_valid", valid_q.size(), 0);
        frames.delete();
        valid_q.delete();
        prev_vc = -1;
        rst_n = 1'b1;
        rel   = cyc;
        check_config("recfg", rel);
        do_read(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), "post_rst");
        do_read(8'h80, 8'h03, "post_rst2");

        check("acc_data_stable", glitches, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL global_timeout: observed cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
